bus_split_arbiter: RTL and testbench

BUS_SPLIT_ARBITER -- requirements
Module: bus_split_arbiter

---
 rtl/bus_bridge_pkg.sv | 19 +
 rtl/bus_split_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_split_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bus_bridge_pkg.sv
// Shared types for the split-capable bus bridge: arbiter state encoding,
// master count and master-index helpers.
package bus_bridge_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int MST_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic [MST_W-1:0] mst_idx_t;

  function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input mst_idx_t idx);
    return NUM_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_split_arbiter.sv
// Two-master round-robin bus arbiter with single-outstanding split
// transactions, resume priority for the split owner and a hold-time limit.
module bus_split_arbiter
  import bus_bridge_pkg::*;
#(
  parameter int MAX_HOLD = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_MASTERS-1:0] m_split_ack,
  input  logic                   s_split,
  input  logic                   s_split_done,
  output logic                   bus_owner,
  output logic                   bus_busy,
  output logic                   split_pending,
  output logic                   timeout_err
);

  localparam int                CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam bit                HOLD_EN   = (MAX_HOLD > 0);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_d, split_ack_d;
  mst_idx_t               owner_q, owner_d;
  mst_idx_t               split_owner_q, split_owner_d;
  mst_idx_t               last_owner_q, last_owner_d;
  logic                   pending_d;
  logic                   resume_q, resume_d;
  logic                   timeout_d;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;

  logic [NUM_MASTERS-1:0] split_mask;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   grant_vld;
  mst_idx_t               grant_sel;

  // The split owner may not re-arbitrate until the slave reports it can resume.
  assign split_mask = split_pending ? idx_to_onehot(split_owner_q) : '0;
  assign eligible   = m_req & ~split_mask;

  assign bus_owner  = owner_q;
  assign bus_busy   = |m_grant;

  // NOTE: every signal written below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    grant_d       = m_grant;
    split_ack_d   = '0;
    owner_d       = owner_q;
    split_owner_d = split_owner_q;
    last_owner_d  = last_owner_q;
    pending_d     = split_pending;
    resume_d      = resume_q;
    timeout_d     = 1'b0;
    hold_cnt_d    = hold_cnt_q;
    grant_vld     = 1'b0;
    grant_sel     = last_owner_q;

    unique case (state_q)
      IDLE: begin
        // A resume opportunity lasts exactly one idle cycle, used or not.
        resume_d = 1'b0;
        if (resume_q && !split_pending && m_req[split_owner_q]) begin
          grant_vld = 1'b1;
          grant_sel = split_owner_q;
        end else if (&eligible) begin
          grant_vld = 1'b1;
          grant_sel = ~last_owner_q;
        end else if (|eligible) begin
          grant_vld = 1'b1;
          grant_sel = mst_idx_t'(eligible[1]);
        end

        if (grant_vld) begin
          state_d      = BUSY;
          grant_d      = idx_to_onehot(grant_sel);
          owner_d      = grant_sel;
          last_owner_d = grant_sel;
          hold_cnt_d   = '0;
        end
      end

      BUSY: begin
        if (s_split && !split_pending && !s_split_done) begin
          state_d       = IDLE;
          grant_d       = '0;
          split_ack_d   = idx_to_onehot(owner_q);
          pending_d     = 1'b1;
          split_owner_d = owner_q;
        end else if (!m_req[owner_q]) begin
          // A voluntary release on the last allowed cycle is not a timeout.
          state_d = IDLE;
          grant_d = '0;
        end else if (HOLD_EN && (hold_cnt_q == HOLD_LAST)) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Resume notification never preempts the current owner; it only arms
    // priority for the next idle cycle, and it wins over the idle-cycle clear.
    if (s_split_done && split_pending) begin
      pending_d = 1'b0;
      resume_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      m_grant       <= '0;
      m_split_ack   <= '0;
      owner_q       <= '0;
      split_owner_q <= '0;
      last_owner_q  <= mst_idx_t'(1);
      split_pending <= 1'b0;
      resume_q      <= 1'b0;
      timeout_err   <= 1'b0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      m_grant       <= grant_d;
      m_split_ack   <= split_ack_d;
      owner_q       <= owner_d;
      split_owner_q <= split_owner_d;
      last_owner_q  <= last_owner_d;
      split_pending <= pending_d;
      resume_q      <= resume_d;
      timeout_err   <= timeout_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Directed, table-driven bench for bus_split_arbiter (MAX_HOLD = 4):
// round-robin, split/resume, ignored events, reset and hold timeout.
module tb_bus_split_arbiter;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       split;
    logic       done;
    logic [1:0] grant;
    logic [1:0] ack;
    logic       owner;
    logic       pend;
    logic       terr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] m_req;
  logic [1:0] m_grant;
  logic [1:0] m_split_ack;
  logic       s_split;
  logic       s_split_done;
  logic       bus_owner;
  logic       bus_busy;
  logic       split_pending;
  logic       timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs[$];

  bus_split_arbiter #(.MAX_HOLD(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_req        (m_req),
    .m_grant      (m_grant),
    .m_split_ack  (m_split_ack),
    .s_split      (s_split),
    .s_split_done (s_split_done),
    .bus_owner    (bus_owner),
    .bus_busy     (bus_busy),
    .split_pending(split_pending),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, required %b", name, act, exp);
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic sp,
                              input logic dn, input logic [1:0] g, input logic [1:0] a,
                              input logic ow, input logic pd, input logic te);
    vec_t v;
    v.rst = r;  v.req = rq;  v.split = sp; v.done = dn;
    v.grant = g; v.ack = a;  v.owner = ow; v.pend = pd; v.terr = te;
    return v;
  endfunction

  // Drive one cycle of inputs, then check the registered response just after the edge.
  task automatic apply(input vec_t v, input string name);
    logic [6:0] act, exp;
    rst          = v.rst;
    m_req        = v.req;
    s_split      = v.split;
    s_split_done = v.done;
    @(posedge clk);
    #1;
    act = {m_grant, m_split_ack, bus_busy, split_pending, timeout_err};
    exp = {v.grant, v.ack, |v.grant, v.pend, v.terr};
    check($sformatf("%s grant/ack/busy/pend/terr", name), 32'(act), 32'(exp));
    if (|v.grant) check($sformatf("%s bus_owner", name), 32'(bus_owner), 32'(v.owner));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; m_req = '0; s_split = 1'b0; s_split_done = 1'b0;

    //            rst  req    spl   dn     grant  ack    own   pend  terr
    // Round-robin with one turnaround cycle between owners.
    vecs.push_back(mk(1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    // Split of master 0, master 1 served, done while master 1 busy, then resume.
    vecs.push_back(mk(0, 2'b11, 1, 0, 2'b00, 2'b01, 0, 1, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b10, 2'b00, 1, 1, 0));
    vecs.push_back(mk(0, 2'b11, 0, 1, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    // Resume beats round-robin: last_owner=0 yet split owner 0 wins.
    vecs.push_back(mk(0, 2'b01, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 1, 0, 2'b00, 2'b01, 0, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    // Second split while pending and split in IDLE are ignored.
    vecs.push_back(mk(0, 2'b01, 1, 0, 2'b00, 2'b01, 0, 1, 0));
    vecs.push_back(mk(0, 2'b10, 0, 0, 2'b10, 2'b00, 1, 1, 0));
    vecs.push_back(mk(0, 2'b10, 1, 0, 2'b10, 2'b00, 1, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0));
    vecs.push_back(mk(0, 2'b00, 1, 0, 2'b00, 2'b00, 0, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    // Done with nothing pending is ignored; split+done together: split ignored.
    vecs.push_back(mk(0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 0, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 2'b10, 1, 1, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    // Reset while busy with a split outstanding discards the split context.
    vecs.push_back(mk(0, 2'b01, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 1, 0, 2'b00, 2'b01, 0, 1, 0));
    vecs.push_back(mk(0, 2'b11, 0, 0, 2'b10, 2'b00, 1, 1, 0));
    vecs.push_back(mk(1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 0, 2'b01, 2'b00, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

    // Hold timeout: master 1 keeps requesting for 4 granted cycles, then a
    // forced release with timeout_err, and waiting master 0 wins next.
    apply(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0), "to_release");
    apply(mk(0, 2'b10, 0, 0, 2'b10, 2'b00, 1, 0, 0), "to_grant1");
    for (int k = 2; k <= 4; k++)
      apply(mk(0, 2'b11, 0, 0, 2'b10, 2'b00, 1, 0, 0), $sformatf("to_hold%0d", k));
    apply(mk(0, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0, 1), "to_forced");
    apply(mk(0, 2'b11, 0, 0, 2'b01, 2'b00, 0, 0, 0), "to_next_m0");

    // Voluntary release coinciding with the limit: no timeout_err.
    for (int k = 2; k <= 4; k++)
      apply(mk(0, 2'b01, 0, 0, 2'b01, 2'b00, 0, 0, 0), $sformatf("rel_hold%0d", k));
    apply(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0), "rel_at_limit");
    apply(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0), "rel_quiet");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
